// File: rtl/mux16_scan_seq.sv
// Sequencer for a 16x1 mux: holds a word on the mux data inputs and steps the select through a window.
// It samples the mux output after a settle interval and streams each sampled bit out with valid/ready/last.
module mux16_scan_seq #(
    parameter bit MSB_FIRST   = 1'b0,
    parameter int HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [3:0]  in_start,
    input  logic [3:0]  in_cnt,
    output logic [15:0] mux_a,
    output logic [3:0]  mux_s,
    input  logic        mux_out,
    output logic        ser_bit,
    output logic        ser_valid,
    input  logic        ser_ready,
    output logic        ser_last,
    output logic        busy
);

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, EMIT} state_t;

    state_t     state;
    logic [3:0] remaining;
    logic [3:0] hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mux_a     <= 16'h0000;
            mux_s     <= 4'h0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            remaining <= 4'h0;
            hold      <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mux_a     <= in_data;
                        mux_s     <= in_start;
                        remaining <= in_cnt;
                        hold      <= HOLD_INIT;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (hold != 4'h0) begin
                        hold <= hold - 4'd1;
                    end else begin
                        // Mux is combinational; after the hold interval its output is settled.
                        ser_bit   <= mux_out;
                        ser_valid <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (ser_ready) begin
                        ser_valid <= 1'b0;
                        if (remaining == 4'h0) begin
                            state <= IDLE;
                        end else begin
                            mux_s     <= MSB_FIRST ? (mux_s - 4'd1) : (mux_s + 4'd1);
                            remaining <= remaining - 4'd1;
                            hold      <= HOLD_INIT;
                            state     <= SETTLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign ser_last = ser_valid & (remaining == 4'h0);

endmodule

// File: tb/tb_mux16_scan_seq.sv
// Directed bench: three instances (default, MSB_FIRST=1, HOLD_CYCLES=3) each driving a behavioural mux.
module tb_mux16_scan_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid [3];
    logic [15:0] in_data;
    logic [3:0]  in_start;
    logic [3:0]  in_cnt;
    logic        ser_ready;
    logic        in_ready [3];
    logic [15:0] mux_a [3];
    logic [3:0]  mux_s [3];
    logic        mux_out [3];
    logic        ser_bit [3];
    logic        ser_valid [3];
    logic        ser_last [3];
    logic        busy [3];

    int passed = 0;
    int total  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_mux
        assign mux_out[g] = mux_a[g][mux_s[g]];
    end

    mux16_scan_seq u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data), .in_start(in_start), .in_cnt(in_cnt),
        .mux_a(mux_a[0]), .mux_s(mux_s[0]), .mux_out(mux_out[0]),
        .ser_bit(ser_bit[0]), .ser_valid(ser_valid[0]), .ser_ready(ser_ready),
        .ser_last(ser_last[0]), .busy(busy[0])
    );

    mux16_scan_seq #(.MSB_FIRST(1'b1), .HOLD_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data), .in_start(in_start), .in_cnt(in_cnt),
        .mux_a(mux_a[1]), .mux_s(mux_s[1]), .mux_out(mux_out[1]),
        .ser_bit(ser_bit[1]), .ser_valid(ser_valid[1]), .ser_ready(ser_ready),
        .ser_last(ser_last[1]), .busy(busy[1])
    );

    mux16_scan_seq #(.MSB_FIRST(1'b0), .HOLD_CYCLES(3)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data), .in_start(in_start), .in_cnt(in_cnt),
        .mux_a(mux_a[2]), .mux_s(mux_s[2]), .mux_out(mux_out[2]),
        .ser_bit(ser_bit[2]), .ser_valid(ser_valid[2]), .ser_ready(ser_ready),
        .ser_last(ser_last[2]), .busy(busy[2])
    );

    // Accepts one frame on instance d with ser_ready held high and records what streams out.
    task automatic run_frame(input int d, input logic [15:0] data, input logic [3:0] start,
                             input logic [3:0] cnt, output logic [15:0] bits,
                             output logic [63:0] sels, output logic [15:0] lasts,
                             output int nbits, output int done_cyc, output int first_cyc);
        in_data = data; in_start = start; in_cnt = cnt; in_valid[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        bits = '0; sels = '0; lasts = '0; nbits = 0; done_cyc = -1; first_cyc = -1;
        for (int c = 0; c < 200; c++) begin
            if (!busy[d]) begin
                done_cyc = c;
                break;
            end
            if (ser_valid[d]) begin
                if (first_cyc < 0) first_cyc = c;
                if (nbits < 16) begin
                    bits[nbits]         = ser_bit[d];
                    sels[nbits*4 +: 4]  = mux_s[d];
                    lasts[nbits]        = ser_last[d];
                end
                nbits++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            total++;
            if ({mux_a[d], mux_s[d], ser_bit[d], ser_valid[d], ser_last[d], busy[d], in_ready[d]} !== {16'h0, 4'h0, 5'b00001})
                $display("FAIL reset_state dut%0d: a=%h s=%h bit=%b vld=%b last=%b busy=%b rdy=%b, want zeros and rdy=1",
                         d, mux_a[d], mux_s[d], ser_bit[d], ser_valid[d], ser_last[d], busy[d], in_ready[d]);
            else passed++;
        end
    endtask

    task automatic test_lsb_sweep();
        logic [15:0] bits, lasts; logic [63:0] sels; int n, done, first;
        run_frame(0, 16'hAAAA, 4'd0, 4'd15, bits, sels, lasts, n, done, first);
        total++; if (n !== 16) $display("FAIL sweep_count: got %0d bits, want 16", n); else passed++;
        total++; if (bits !== 16'hAAAA) $display("FAIL sweep_bits: got %h, want aaaa", bits); else passed++;
        total++; if (sels !== 64'hFEDCBA9876543210) $display("FAIL sweep_sel: got %h, want fedcba9876543210", sels); else passed++;
        total++; if (lasts !== 16'h8000) $display("FAIL sweep_last: got %h, want 8000", lasts); else passed++;
        total++; if (first !== 1) $display("FAIL sweep_first_valid: got cycle %0d, want 1", first); else passed++;
        total++; if (done !== 32) $display("FAIL sweep_done: busy fell at %0d, want 32", done); else passed++;
        total++; if (in_ready[0] !== 1'b1 || mux_a[0] !== 16'hAAAA)
            $display("FAIL sweep_idle_retain: rdy=%b a=%h, want 1 aaaa", in_ready[0], mux_a[0]); else passed++;
    endtask

    task automatic test_msb_sweep();
        logic [15:0] bits, lasts; logic [63:0] sels; int n, done, first;
        run_frame(1, 16'hAAAA, 4'd15, 4'd15, bits, sels, lasts, n, done, first);
        total++; if (bits !== 16'h5555 || n !== 16) $display("FAIL msb_bits: got %h n=%0d, want 5555 n=16", bits, n); else passed++;
        total++; if (sels !== 64'h0123456789ABCDEF) $display("FAIL msb_sel: got %h, want 0123456789abcdef", sels); else passed++;
        total++; if (lasts !== 16'h8000 || done !== 32) $display("FAIL msb_last_done: last=%h done=%0d, want 8000 32", lasts, done); else passed++;
    endtask

    task automatic test_wrap();
        logic [15:0] bits, lasts; logic [63:0] sels; int n, done, first;
        run_frame(0, 16'h8001, 4'd14, 4'd3, bits, sels, lasts, n, done, first);
        total++; if (n !== 4 || bits !== 16'h0006) $display("FAIL wrap_bits: got %h n=%0d, want 0006 n=4", bits, n); else passed++;
        total++; if (sels[15:0] !== 16'h10FE) $display("FAIL wrap_sel: got %h, want 10fe", sels[15:0]); else passed++;
        total++; if (lasts !== 16'h0008 || done !== 8) $display("FAIL wrap_last_done: last=%h done=%0d, want 0008 8", lasts, done); else passed++;
    endtask

    task automatic test_backpressure();
        int nbits = 0, ones = 0, nlast = 0, last_idx = -1;
        bit stalled = 0;
        in_data = 16'h000F; in_start = 4'd0; in_cnt = 4'd3; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        for (int c = 0; c < 100 && busy[0]; c++) begin
            if (ser_valid[0]) begin
                if (nbits == 1 && !stalled) begin
                    ser_ready = 1'b0;
                    repeat (5) begin
                        @(posedge clk); #1;
                        total++;
                        if ({ser_valid[0], ser_bit[0], mux_s[0]} !== {1'b1, 1'b1, 4'd1})
                            $display("FAIL stall_stable: vld=%b bit=%b s=%0d, want 1 1 1", ser_valid[0], ser_bit[0], mux_s[0]);
                        else passed++;
                    end
                    ser_ready = 1'b1;
                    stalled = 1;
                end
                if (ser_last[0]) begin nlast++; last_idx = nbits; end
                ones += int'(ser_bit[0]);
                nbits++;
            end
            @(posedge clk); #1;
        end
        total++; if (nbits !== 4 || ones !== 4) $display("FAIL stall_bits: got %0d bits, %0d ones, want 4 4", nbits, ones); else passed++;
        total++; if (nlast !== 1 || last_idx !== 3) $display("FAIL stall_last: got %0d lasts at %0d, want 1 at 3", nlast, last_idx); else passed++;
        total++; if (busy[0] !== 1'b0) $display("FAIL stall_done: busy=%b, want 0", busy[0]); else passed++;
    endtask

    task automatic test_hold_and_ignore();
        in_data = 16'h0010; in_start = 4'd4; in_cnt = 4'd0; in_valid[2] = 1'b1;
        @(posedge clk); #1;
        in_data = 16'hFFFF; in_start = 4'd0; in_cnt = 4'd5;
        for (int e = 0; e < 3; e++) begin
            total++;
            if (ser_valid[2] !== 1'b0 || in_ready[2] !== 1'b0)
                $display("FAIL hold_settle edge%0d: vld=%b rdy=%b, want 0 0", e, ser_valid[2], in_ready[2]);
            else passed++;
            if (e == 1) in_valid[2] = 1'b0;
            @(posedge clk); #1;
        end
        total++;
        if ({ser_valid[2], ser_bit[2], ser_last[2], mux_s[2], mux_a[2]} !== {3'b111, 4'd4, 16'h0010})
            $display("FAIL hold_emit: vld=%b bit=%b last=%b s=%0d a=%h, want 1 1 1 4 0010",
                     ser_valid[2], ser_bit[2], ser_last[2], mux_s[2], mux_a[2]);
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({busy[2], in_ready[2], ser_valid[2]} !== 3'b010 || mux_a[2] !== 16'h0010)
            $display("FAIL hold_done: busy=%b rdy=%b vld=%b a=%h, want 0 1 0 0010", busy[2], in_ready[2], ser_valid[2], mux_a[2]);
        else passed++;
    endtask

    task automatic test_reset_midframe();
        logic [15:0] bits, lasts; logic [63:0] sels; int n, done, first;
        int seen = 0;
        in_data = 16'hFFFF; in_start = 4'd0; in_cnt = 4'd15; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        for (int c = 0; c < 100 && seen < 5; c++) begin
            if (ser_valid[0]) seen++;
            if (seen < 5) begin @(posedge clk); #1; end
        end
        total++; if (seen !== 5 || mux_s[0] !== 4'd4) $display("FAIL midrst_reach: seen=%0d s=%0d, want 5 4", seen, mux_s[0]); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({mux_a[0], mux_s[0], ser_bit[0], ser_valid[0], ser_last[0], busy[0], in_ready[0]} !== {16'h0, 4'h0, 5'b00001})
            $display("FAIL midrst_clear: a=%h s=%h bit=%b vld=%b last=%b busy=%b rdy=%b, want zeros and rdy=1",
                     mux_a[0], mux_s[0], ser_bit[0], ser_valid[0], ser_last[0], busy[0], in_ready[0]);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(0, 16'h1234, 4'd3, 4'd2, bits, sels, lasts, n, done, first);
        total++; if (n !== 3 || bits !== 16'h0006) $display("FAIL midrst_new_bits: got %h n=%0d, want 0006 n=3", bits, n); else passed++;
        total++; if (sels[11:0] !== 12'h543 || lasts !== 16'h0004 || done !== 6)
            $display("FAIL midrst_new_sel: sel=%h last=%h done=%0d, want 543 0004 6", sels[11:0], lasts, done); else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) in_valid[d] = 1'b0;
        in_data = 16'h0; in_start = 4'h0; in_cnt = 4'h0; ser_ready = 1'b1;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_lsb_sweep();
        test_msb_sweep();
        test_wrap();
        test_backpressure();
        @(posedge clk); #1;
        test_hold_and_ignore();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
